melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_sequencer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Melody player: walks note words from an external ROM, times the silent gap and
// tone phases of each note, and drives a square-wave tone plus one-hot degree lights.
module melody_sequencer #(
   parameter int SONG_W      = 2,
   parameter int ADDR_W      = 6,
   parameter int UNIT_CYCLES = 12500000,
   parameter int GAP_CYCLES  = 2500000,
   parameter int TONE_SHIFT  = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SONG_W-1:0]        song_sel,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     skip,
   input  logic                     pause,
   input  logic                     loop_en,
   output logic [SONG_W+ADDR_W-1:0] rom_addr,
   input  logic [7:0]               rom_data,
   output logic                     pwm,
   output logic [6:0]               lights,
   output logic                     is_high,
   output logic                     is_low,
   output logic                     busy,
   output logic                     done,
   output logic [ADDR_W-1:0]        note_idx
);
   localparam int CNT_W  = $clog2(8 * UNIT_CYCLES + 1);
   localparam int HALF_W = 18;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, GAP, PLAY} state_t;

   state_t                   state_reg;
   logic [SONG_W-1:0]        song_reg;
   logic [ADDR_W-1:0]        note_idx_reg;
   logic [SONG_W+ADDR_W-1:0] rom_addr_reg;
   logic                     past_end_reg;
   logic [CNT_W-1:0]         note_cnt_reg;
   logic [CNT_W-1:0]         play_len_reg;
   logic [HALF_W-1:0]        tone_cnt_reg;
   logic [HALF_W-1:0]        half_reg;
   logic                     tone_level_reg;
   logic                     note_rest_reg;
   logic                     note_hi_reg;
   logic                     note_lo_reg;
   logic [6:0]               note_lights_reg;
   logic                     pwm_reg;
   logic [6:0]               lights_reg;
   logic                     is_high_reg;
   logic                     is_low_reg;
   logic                     busy_reg;
   logic                     done_reg;

   function automatic logic [HALF_W-1:0] half_base(input logic [1:0] oct, input logic [2:0] deg);
      logic [HALF_W-1:0] h;
      h = '0;
      case ({oct, deg})
         5'b01_001: h = 18'd190840;
         5'b01_010: h = 18'd170068;
         5'b01_011: h = 18'd151515;
         5'b01_100: h = 18'd143266;
         5'b01_101: h = 18'd127551;
         5'b01_110: h = 18'd113636;
         5'b01_111: h = 18'd101215;
         5'b10_001: h = 18'd95602;
         5'b10_010: h = 18'd85179;
         5'b10_011: h = 18'd75873;
         5'b10_100: h = 18'd71633;
         5'b10_101: h = 18'd63776;
         5'b10_110: h = 18'd56818;
         5'b10_111: h = 18'd50607;
         5'b11_001: h = 18'd47801;
         5'b11_010: h = 18'd42553;
         5'b11_011: h = 18'd37936;
         5'b11_100: h = 18'd35791;
         5'b11_101: h = 18'd31888;
         5'b11_110: h = 18'd28409;
         5'b11_111: h = 18'd25304;
         default:   h = '0;
      endcase
      return h;
   endfunction

   // Decode of the word on rom_data; only meaningful while in WAIT.
   logic [6:0]        dec_onehot;
   logic              dec_rest;
   logic              dec_end;
   logic [6:0]        dec_lights;
   logic              dec_hi;
   logic              dec_lo;
   logic [HALF_W-1:0] dec_half;
   logic [CNT_W-1:0]  dec_play_len;

   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_deg
         assign dec_onehot[gi] = (rom_data[5:3] == 3'(7 - gi));
      end
   endgenerate

   assign dec_rest     = (rom_data[7:6] == 2'b00) || (rom_data[5:3] == 3'd0);
   assign dec_end      = past_end_reg || (rom_data == 8'h00);
   assign dec_lights   = dec_rest ? 7'd0 : dec_onehot;
   assign dec_hi       = !dec_rest && (rom_data[7:6] == 2'b11);
   assign dec_lo       = !dec_rest && (rom_data[7:6] == 2'b01);
   assign dec_half     = half_base(rom_data[7:6], rom_data[5:3]) >> TONE_SHIFT;
   assign dec_play_len = CNT_W'((int'(rom_data[2:0]) + 1) * UNIT_CYCLES - GAP_CYCLES);

   // PLAY entry straight from WAIT (zero gap) must use the word still on rom_data.
   logic [6:0]        ent_lights;
   logic              ent_hi;
   logic              ent_lo;
   assign ent_lights = (state_reg == WAIT) ? dec_lights : note_lights_reg;
   assign ent_hi     = (state_reg == WAIT) ? dec_hi     : note_hi_reg;
   assign ent_lo     = (state_reg == WAIT) ? dec_lo     : note_lo_reg;

   logic [ADDR_W-1:0] idx_inc;
   logic              tone_wrap;
   logic              advance;
   assign idx_inc   = note_idx_reg + 1'b1;
   assign tone_wrap = ({1'b0, tone_cnt_reg} + 19'd1) >= {1'b0, half_reg};

   always_comb begin
      advance = 1'b0;
      if ((state_reg == GAP || state_reg == PLAY) && skip)
         advance = 1'b1;
      else if (state_reg == PLAY && !pause && note_cnt_reg == play_len_reg - 1'b1)
         advance = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         song_reg        <= '0;
         note_idx_reg    <= '0;
         rom_addr_reg    <= '0;
         past_end_reg    <= 1'b0;
         note_cnt_reg    <= '0;
         play_len_reg    <= '0;
         tone_cnt_reg    <= '0;
         half_reg        <= '0;
         tone_level_reg  <= 1'b0;
         note_rest_reg   <= 1'b0;
         note_hi_reg     <= 1'b0;
         note_lo_reg     <= 1'b0;
         note_lights_reg <= '0;
         pwm_reg         <= 1'b0;
         lights_reg      <= '0;
         is_high_reg     <= 1'b0;
         is_low_reg      <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (stop) begin
            state_reg      <= IDLE;
            note_idx_reg   <= '0;
            rom_addr_reg   <= '0;
            past_end_reg   <= 1'b0;
            note_cnt_reg   <= '0;
            tone_cnt_reg   <= '0;
            tone_level_reg <= 1'b0;
            pwm_reg        <= 1'b0;
            lights_reg     <= '0;
            is_high_reg    <= 1'b0;
            is_low_reg     <= 1'b0;
            busy_reg       <= 1'b0;
         end else if (start) begin
            state_reg      <= FETCH;
            song_reg       <= song_sel;
            note_idx_reg   <= '0;
            rom_addr_reg   <= {song_sel, {ADDR_W{1'b0}}};
            past_end_reg   <= 1'b0;
            note_cnt_reg   <= '0;
            tone_cnt_reg   <= '0;
            tone_level_reg <= 1'b0;
            pwm_reg        <= 1'b0;
            lights_reg     <= '0;
            is_high_reg    <= 1'b0;
            is_low_reg     <= 1'b0;
            busy_reg       <= 1'b1;
         end else if (advance) begin
            state_reg    <= FETCH;
            note_cnt_reg <= '0;
            pwm_reg      <= 1'b0;
            lights_reg   <= '0;
            is_high_reg  <= 1'b0;
            is_low_reg   <= 1'b0;
            // Past the last slot: refetch in place and treat the result as the end marker.
            if (note_idx_reg == {ADDR_W{1'b1}}) begin
               past_end_reg <= 1'b1;
            end else begin
               note_idx_reg <= idx_inc;
               rom_addr_reg <= {song_reg, idx_inc};
            end
         end else begin
            case (state_reg)
               FETCH: state_reg <= WAIT;
               WAIT: begin
                  if (dec_end) begin
                     past_end_reg <= 1'b0;
                     if (loop_en) begin
                        state_reg    <= FETCH;
                        note_idx_reg <= '0;
                        rom_addr_reg <= {song_reg, {ADDR_W{1'b0}}};
                     end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                     end
                  end else begin
                     note_lights_reg <= dec_lights;
                     note_hi_reg     <= dec_hi;
                     note_lo_reg     <= dec_lo;
                     note_rest_reg   <= dec_rest;
                     half_reg        <= dec_half;
                     play_len_reg    <= dec_play_len;
                     note_cnt_reg    <= '0;
                     if (GAP_CYCLES == 0) begin
                        state_reg      <= PLAY;
                        tone_cnt_reg   <= '0;
                        tone_level_reg <= 1'b0;
                        pwm_reg        <= 1'b0;
                        lights_reg     <= ent_lights;
                        is_high_reg    <= ent_hi;
                        is_low_reg     <= ent_lo;
                     end else begin
                        state_reg <= GAP;
                     end
                  end
               end
               GAP: begin
                  if (!pause) begin
                     if (note_cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
                        state_reg      <= PLAY;
                        note_cnt_reg   <= '0;
                        tone_cnt_reg   <= '0;
                        tone_level_reg <= 1'b0;
                        pwm_reg        <= 1'b0;
                        lights_reg     <= ent_lights;
                        is_high_reg    <= ent_hi;
                        is_low_reg     <= ent_lo;
                     end else begin
                        note_cnt_reg <= note_cnt_reg + 1'b1;
                     end
                  end
               end
               PLAY: begin
                  if (pause) begin
                     pwm_reg     <= 1'b0;
                     lights_reg  <= '0;
                     is_high_reg <= 1'b0;
                     is_low_reg  <= 1'b0;
                  end else begin
                     note_cnt_reg <= note_cnt_reg + 1'b1;
                     lights_reg   <= note_lights_reg;
                     is_high_reg  <= note_hi_reg;
                     is_low_reg   <= note_lo_reg;
                     if (tone_wrap) begin
                        tone_cnt_reg   <= '0;
                        tone_level_reg <= ~tone_level_reg;
                        pwm_reg        <= ~tone_level_reg & ~note_rest_reg;
                     end else begin
                        tone_cnt_reg <= tone_cnt_reg + 1'b1;
                        pwm_reg      <= tone_level_reg & ~note_rest_reg;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign rom_addr = rom_addr_reg;
   assign pwm      = pwm_reg;
   assign lights   = lights_reg;
   assign is_high  = is_high_reg;
   assign is_low   = is_low_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign note_idx = note_idx_reg;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: a per-note elapsed-time model checks every
// cycle, and literal checks pin timing of the scenarios.
module tb_melody_sequencer;
   localparam int SONG_W = 2;
   localparam int ADDR_W = 3;
   localparam int UNIT   = 10;
   localparam int GAP    = 2;
   localparam int SHIFT  = 12;

   logic       clk = 1'b0;
   logic       rst, start, stop, skip, pause, loop_en;
   logic [1:0] song_sel;
   logic [4:0] rom_addr;
   logic [7:0] rom_data = 8'h00;
   logic       pwm, is_high, is_low, busy, done;
   logic [6:0] lights;
   logic [2:0] note_idx;

   always #5 clk = ~clk;

   melody_sequencer #(
      .SONG_W(SONG_W), .ADDR_W(ADDR_W), .UNIT_CYCLES(UNIT),
      .GAP_CYCLES(GAP), .TONE_SHIFT(SHIFT)
   ) dut (
      .clk(clk), .rst(rst), .song_sel(song_sel), .start(start), .stop(stop),
      .skip(skip), .pause(pause), .loop_en(loop_en), .rom_addr(rom_addr),
      .rom_data(rom_data), .pwm(pwm), .lights(lights), .is_high(is_high),
      .is_low(is_low), .busy(busy), .done(done), .note_idx(note_idx)
   );

   logic [7:0] rom_mem [0:31];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   int half_tab [0:20] = '{190840, 170068, 151515, 143266, 127551, 113636, 101215,
                           95602, 85179, 75873, 71633, 63776, 56818, 50607,
                           47801, 42553, 37936, 35791, 31888, 28409, 25304};

   function automatic bit is_rest(input logic [7:0] w);
      return (w[7:6] == 2'b00) || (w[5:3] == 3'd0);
   endfunction

   function automatic int half_of(input logic [7:0] w);
      return half_tab[(int'(w[7:6]) - 1) * 7 + int'(w[5:3]) - 1] >> SHIFT;
   endfunction

   // Model: m_t counts cycles since the note's fetch began (0 fetch, 1 wait, then gap, then tone).
   bit         m_busy = 0, m_done = 0, m_past = 0, m_paused = 0;
   logic [1:0] m_song = 0;
   logic [2:0] m_idx = 0;
   logic [4:0] m_addr = 0;
   logic [7:0] m_word = 0;
   int         m_t = 0;

   task automatic next_note();
      if (m_idx == 3'd7) m_past = 1;
      else begin
         m_idx  = m_idx + 3'd1;
         m_addr = {m_song, m_idx};
      end
      m_t = 0;
   endtask

   always @(posedge clk) begin
      logic [7:0] w;
      m_done   = 0;
      m_paused = 0;
      if (rst) begin
         m_busy = 0; m_idx = 0; m_song = 0; m_addr = 0; m_past = 0;
      end else if (stop) begin
         m_busy = 0; m_idx = 0; m_addr = 0; m_past = 0;
      end else if (start) begin
         m_busy = 1; m_song = song_sel; m_idx = 0; m_addr = {song_sel, 3'd0};
         m_t = 0; m_past = 0;
      end else if (m_busy) begin
         if (m_t >= 2 && skip) next_note();
         else if (m_t >= 2 && pause) m_paused = 1;
         else if (m_t == 1) begin
            w = m_past ? 8'h00 : rom_mem[{m_song, m_idx}];
            if (w == 8'h00) begin
               m_past = 0;
               if (loop_en) begin
                  m_idx = 0; m_addr = {m_song, 3'd0}; m_t = 0;
               end else begin
                  m_busy = 0; m_done = 1;
               end
            end else begin
               m_word = w;
               m_t = 2;
            end
         end else if (m_t >= 2 && m_t == 1 + (int'(m_word[2:0]) + 1) * UNIT) next_note();
         else m_t++;
      end
   end

   always @(negedge clk) begin
      bit         in_play;
      logic [6:0] e_l;
      bit         e_p, e_h, e_lo;
      if (chk_en) begin
         in_play = m_busy && m_t >= 2 + GAP && !m_paused && !is_rest(m_word);
         e_l  = in_play ? 7'(64 >> (int'(m_word[5:3]) - 1)) : 7'd0;
         e_h  = in_play && m_word[7:6] == 2'b11;
         e_lo = in_play && m_word[7:6] == 2'b01;
         e_p  = in_play && (((m_t - (2 + GAP)) / half_of(m_word)) % 2 == 1);
         total++;
         if (busy !== m_busy || done !== m_done || rom_addr !== m_addr || note_idx !== m_idx ||
             pwm !== e_p || lights !== e_l || is_high !== e_h || is_low !== e_lo) begin
            bad++;
            $display("FAIL model @%0t got b=%b d=%b a=%0d i=%0d p=%b l=%b h=%b lo=%b want b=%b d=%b a=%0d i=%0d p=%b l=%b h=%b lo=%b",
                     $time, busy, done, rom_addr, note_idx, pwm, lights, is_high, is_low,
                     m_busy, m_done, m_addr, m_idx, e_p, e_l, e_h, e_lo);
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start(input logic [1:0] s);
      song_sel = s; start = 1; tick(1); start = 0;
   endtask

   initial begin
      int n;
      int min_addr;
      rst = 1; start = 0; stop = 0; skip = 0; pause = 0; loop_en = 0; song_sel = 0;
      for (int i = 0; i < 32; i++) rom_mem[i] = 8'h00;
      rom_mem[0] = 8'hD1; rom_mem[1] = 8'h88;
      rom_mem[8] = 8'h88;
      rom_mem[16] = 8'hD1;
      rom_mem[24] = 8'h48; rom_mem[25] = 8'h08; rom_mem[26] = 8'h40; rom_mem[27] = 8'hF8;
      rom_mem[28] = 8'h50; rom_mem[29] = 8'h98; rom_mem[30] = 8'hE0; rom_mem[31] = 8'h70;
      tick(1); chk_en = 1; tick(2);
      check("rst_busy", busy, 0); check("rst_addr", rom_addr, 0);
      check("rst_lights", lights, 0); check("rst_done", done, 0);
      rst = 0;

      pulse_start(2'd1);
      check("A_addr", rom_addr, 8); check("A_busy", busy, 1);
      tick(2); check("A_gap_lights", lights, 0);
      tick(2); check("A_play_lights", lights, 64); check("A_play_pwm", pwm, 0);
      tick(7); check("A_last_lights", lights, 64); check("A_last_pwm", pwm, 0);
      tick(1); check("A_idx", note_idx, 1); check("A_addr2", rom_addr, 9);
      tick(2); check("A_done", done, 1); check("A_busy_end", busy, 0);
      tick(1); check("A_done_pulse", done, 0);
      $display("txn A: song1 single mid-do note then end");

      pulse_start(2'd2);
      tick(4); check("B_lights", lights, 32); check("B_high", is_high, 1); check("B_pwm0", pwm, 0);
      tick(9); check("B_pwm_p9", pwm, 0);
      tick(1); check("B_pwm_p10", pwm, 1);
      tick(7); check("B_pwm_p17", pwm, 1);
      tick(1); check("B_exit_pwm", pwm, 0); check("B_exit_lights", lights, 0);
      tick(2); check("B_done", done, 1);
      tick(1);
      $display("txn B: high-re note 18 play cycles");

      loop_en = 1;
      pulse_start(2'd1);
      tick(12); check("C_addr9", rom_addr, 9);
      tick(2); check("C_loop_addr", rom_addr, 8); check("C_no_done", done, 0);
      check("C_busy", busy, 1);
      loop_en = 0;
      n = 0;
      while (!done && n < 40) begin tick(1); n++; end
      check("C_end_latency", n, 14);
      tick(1);
      $display("txn C: loop then end after loop_en drop");

      pulse_start(2'd0);
      tick(8); check("D_lights", lights, 32);
      pause = 1;
      tick(1); check("D_pause_lights", lights, 0); check("D_pause_pwm", pwm, 0);
      tick(4); check("D_pause_lights5", lights, 0);
      pause = 0;
      tick(1); check("D_resume_lights", lights, 32);
      n = 14;
      while (note_idx != 3'd1 && n < 60) begin tick(1); n++; end
      check("D_note_end", n, 27);
      tick(4); check("D_n2_lights", lights, 64);
      skip = 1; tick(1); skip = 0;
      check("D_skip_idx", note_idx, 2); check("D_skip_addr", rom_addr, 2);
      check("D_skip_lights", lights, 0);
      tick(2); check("D_done", done, 1);
      tick(1);
      $display("txn D: pause 5 cycles and skip");

      pulse_start(2'd3);
      tick(4); check("E_lights", lights, 64); check("E_low", is_low, 1);
      min_addr = rom_addr;
      n = 4;
      while (!done && n < 200) begin
         tick(1); n++;
         if (busy && rom_addr < min_addr) min_addr = rom_addr;
      end
      check("E_done_at", n, 98); check("E_min_addr", min_addr, 24);
      check("E_last_addr", rom_addr, 31);
      tick(1);
      pulse_start(2'd3);
      tick(6);
      stop = 1; tick(1); stop = 0;
      check("E_stop_busy", busy, 0); check("E_stop_done", done, 0);
      check("E_stop_lights", lights, 0);
      tick(3); check("E_stop_done_later", done, 0);
      $display("txn E: full song3 end and stop mid-note");

      pulse_start(2'd2);
      tick(8);
      rst = 1; start = 1; tick(1); rst = 0; start = 0;
      check("F_busy", busy, 0); check("F_addr", rom_addr, 0); check("F_idx", note_idx, 0);
      check("F_lights", lights, 0); check("F_high", is_high, 0); check("F_pwm", pwm, 0);
      check("F_done", done, 0);
      tick(2);
      $display("txn F: rst with start mid-play");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
